// File: rtl/iter_mul.sv
// Iterative multiplier: full 2*XLEN-bit product in three signedness modes,
// retiring STEP multiplier bits per BUSY cycle, with output backpressure and flush.
module iter_mul #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned STEP = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_mul_valid,
  input  logic            io_flush,
  input  logic [1:0]      io_mul_signed,
  input  logic [XLEN-1:0] io_multiplicand,
  input  logic [XLEN-1:0] io_multiplier,
  input  logic            io_out_ready,
  output logic            io_mul_ready,
  output logic            io_out_valid,
  output logic [XLEN-1:0] io_result_hi,
  output logic [XLEN-1:0] io_result_lo
);

  localparam int unsigned NCyc = XLEN / STEP;
  localparam int unsigned CntW = $clog2(NCyc + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_t;

  state_t              state;
  logic [XLEN-1:0]     mcand;
  logic [XLEN-1:0]     mplier;
  logic [2*XLEN-1:0]   acc;
  logic [CntW-1:0]     cnt;
  logic                neg;
  logic [XLEN-1:0]     res_hi;
  logic [XLEN-1:0]     res_lo;

  logic                sign_a;
  logic                sign_b;
  logic [XLEN-1:0]     mag_a;
  logic [XLEN-1:0]     mag_b;
  logic [XLEN+STEP-1:0] upper_sum;
  logic [2*XLEN-1:0]   acc_next;
  logic [2*XLEN-1:0]   fixed;

  // Mode 2'b01 decodes like 2'b00: only bit 1 signs A, only 2'b11 signs B.
  assign sign_a = io_mul_signed[1] & io_multiplicand[XLEN-1];
  assign sign_b = (io_mul_signed == 2'b11) & io_multiplier[XLEN-1];
  assign mag_a  = sign_a ? (~io_multiplicand + XLEN'(1)) : io_multiplicand;
  assign mag_b  = sign_b ? (~io_multiplier + XLEN'(1)) : io_multiplier;

  assign upper_sum = {{STEP{1'b0}}, acc[2*XLEN-1:XLEN]}
                   + ({{STEP{1'b0}}, mcand} * {{XLEN{1'b0}}, mplier[STEP-1:0]});
  // The carry-out of the partial sum becomes the top bits after the right shift.
  assign acc_next  = {upper_sum, acc[XLEN-1:STEP]};
  assign fixed     = neg ? (~acc + (2*XLEN)'(1)) : acc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= StIdle;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (io_mul_valid && !io_flush) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= sign_a ^ sign_b;
            acc    <= '0;
            cnt    <= CntW'(NCyc);
            state  <= StBusy;
          end
        end
        StBusy: begin
          if (io_flush) begin
            state <= StIdle;
          end else begin
            acc    <= acc_next;
            mplier <= mplier >> STEP;
            cnt    <= cnt - CntW'(1);
            if (cnt == CntW'(1)) state <= StFix;
          end
        end
        StFix: begin
          if (io_flush) begin
            state <= StIdle;
          end else begin
            res_hi <= fixed[2*XLEN-1:XLEN];
            res_lo <= fixed[XLEN-1:0];
            state  <= StDone;
          end
        end
        StDone: begin
          if (io_flush || io_out_ready) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign io_mul_ready = (state == StIdle);
  assign io_out_valid = (state == StDone);
  assign io_result_hi = res_hi;
  assign io_result_lo = res_lo;

endmodule
